// File: rtl/mipi_hs_byte_aligner_if.sv
// ============================================================================
// mipi_hs_byte_aligner_if
// ----------------------------------------------------------------------------
// Purpose : Bundles the lane-side stream, the re-hunt control and the aligned
//           output of the D-PHY HS byte aligner into one interface.
// Signals :
//   align_rst       re-hunt request (synchronous, active high)
//   data_in  [7:0]  unaligned deserialized byte, bit 0 = earliest serial bit
//   data_out_valid  data_out holds an aligned payload byte
//   data_out [7:0]  aligned payload byte, bit 0 = earliest serial bit
//   locked          sync byte found, bit offset frozen
//   sync_offset[2:0] locked bit offset
// Modports:
//   master  upstream/consumer side (drives data_in and align_rst)
//   slave   the aligner itself
// ============================================================================
interface mipi_hs_byte_aligner_if;
    logic       align_rst;
    logic [7:0] data_in;
    logic       data_out_valid;
    logic [7:0] data_out;
    logic       locked;
    logic [2:0] sync_offset;

    modport master (
        output align_rst,
        output data_in,
        input  data_out_valid,
        input  data_out,
        input  locked,
        input  sync_offset
    );

    modport slave (
        input  align_rst,
        input  data_in,
        output data_out_valid,
        output data_out,
        output locked,
        output sync_offset
    );
endinterface

// File: rtl/mipi_hs_byte_aligner.sv
// ============================================================================
// mipi_hs_byte_aligner
// ----------------------------------------------------------------------------
// Purpose : Recovers byte alignment of one MIPI D-PHY HS data lane. The
//           deserializer delivers bytes with an arbitrary boundary; this block
//           hunts for the HS sync byte at any of the 8 bit offsets, freezes
//           the offset once found, and then emits re-aligned payload bytes
//           every byte_clk. The sync byte itself is never emitted.
// Ports   :
//   byte_clk   in  byte clock, all logic on its rising edge
//   sys_rst    in  asynchronous active-high reset
//   lane       slave modport of mipi_hs_byte_aligner_if:
//                align_rst, data_in          (inputs)
//                data_out_valid, data_out,
//                locked, sync_offset         (outputs)
// Parameter:
//   SYNC_PATTERN  sync byte value, bit 0 is the first serial bit (0xB8)
// Build option:
//   MIPI_ALIGN_SOFT_SYNC_EN  when defined, the hunt also accepts a candidate
//                            one bit away from SYNC_PATTERN; exact matches at
//                            any offset still take priority.
// ============================================================================
module mipi_hs_byte_aligner #(
    parameter logic [7:0] SYNC_PATTERN = 8'hB8
) (
    input  logic                          byte_clk,
    input  logic                          sys_rst,
    mipi_hs_byte_aligner_if.slave         lane
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;

    // Two-byte history: r_old holds the older byte, so window bit 0 is the
    // earliest serial bit still visible.
    logic [7:0] r_new_reg;
    logic [7:0] r_old_reg;
    logic [15:0] window;

    logic [7:0] data_out_reg;
    logic [7:0] data_out_next;
    logic       valid_reg;
    logic       valid_next;
    logic [2:0] offset_reg;
    logic [2:0] offset_next;

    logic [7:0] cand [8];
    logic [7:0] exact_hit;
    logic [7:0] soft_hit;
    logic       match_found;
    logic [2:0] match_offset;

    assign window = {r_new_reg, r_old_reg};

    // One candidate byte per bit offset, each with its own comparator.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cand
            logic [7:0] diff;
            assign cand[gi]      = window[gi+7:gi];
            assign diff          = cand[gi] ^ SYNC_PATTERN;
            assign exact_hit[gi] = (diff == 8'd0);
`ifdef MIPI_ALIGN_SOFT_SYNC_EN
            // At most one differing bit: clearing the lowest set bit leaves zero.
            assign soft_hit[gi]  = ((diff & (diff - 8'd1)) == 8'd0);
`else
            assign soft_hit[gi]  = exact_hit[gi];
`endif
        end
    endgenerate

    // Offset selection: scan from high to low so the lowest offset wins, and
    // run the exact scan last so any exact hit overrides a 1-bit hit.
    always_comb begin
        match_found  = 1'b0;
        match_offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (soft_hit[k]) begin
                match_found  = 1'b1;
                match_offset = 3'(k);
            end
        end
        for (int k = 7; k >= 0; k--) begin
            if (exact_hit[k]) begin
                match_found  = 1'b1;
                match_offset = 3'(k);
            end
        end
    end

    // Next-state and output logic. A re-hunt request overrides everything,
    // including a match in the same cycle. data_out keeps its last value
    // whenever no new payload byte is produced.
    always_comb begin
        state_next    = state_reg;
        data_out_next = data_out_reg;
        valid_next    = 1'b0;
        offset_next   = offset_reg;
        if (lane.align_rst) begin
            state_next  = HUNT;
            offset_next = 3'd0;
        end else begin
            case (state_reg)
                HUNT: begin
                    if (match_found) begin
                        state_next  = LOCKED;
                        offset_next = match_offset;
                    end
                end
                LOCKED: begin
                    data_out_next = cand[offset_reg];
                    valid_next    = 1'b1;
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge byte_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg    <= HUNT;
            r_new_reg    <= 8'd0;
            r_old_reg    <= 8'd0;
            data_out_reg <= 8'd0;
            valid_reg    <= 1'b0;
            offset_reg   <= 3'd0;
        end else begin
            state_reg    <= state_next;
            data_out_reg <= data_out_next;
            valid_reg    <= valid_next;
            offset_reg   <= offset_next;
            if (lane.align_rst) begin
                r_new_reg <= 8'd0;
                r_old_reg <= 8'd0;
            end else begin
                r_new_reg <= lane.data_in;
                r_old_reg <= r_new_reg;
            end
        end
    end

    assign lane.data_out       = data_out_reg;
    assign lane.data_out_valid = valid_reg;
    assign lane.locked         = (state_reg == LOCKED);
    assign lane.sync_offset    = offset_reg;

endmodule

// File: tb/tb_mipi_hs_byte_aligner.sv
// ============================================================================
// tb_mipi_hs_byte_aligner
// ----------------------------------------------------------------------------
// Directed bench for mipi_hs_byte_aligner. Bursts are built as a serial bit
// stream (zero leader, sync byte at a chosen bit shift, payload), cut into
// deserializer words and driven one per clock. Each payload byte is pushed
// to a scoreboard together with the clock edge on which it must appear:
// two edges after the edge that samples the word in which that byte starts.
// ============================================================================
module tb_mipi_hs_byte_aligner;

`ifdef MIPI_ALIGN_SOFT_SYNC_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mipi_hs_byte_aligner_if bus();

    mipi_hs_byte_aligner #(.SYNC_PATTERN(8'hB8)) dut (
        .byte_clk (clk),
        .sys_rst  (rst),
        .lane     (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] w   [40];
    int         wlen = 0;
    logic [7:0] pay [16];
    int         npay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    endtask

    // Scoreboard side: every valid output must match the oldest expectation,
    // both in value and in the edge it appears on.
    always @(negedge clk) begin
        if (!rst && bus.data_out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'(bus.data_out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("latency_edge", 32'(cyc), 32'(e.cyc));
                $display("out byte %02h at edge %0d (expected %02h at edge %0d)",
                         bus.data_out, cyc, e.data, e.cyc);
            end
        end
    end

    task automatic set_payload(input logic [7:0] first, input int n);
        npay = n;
        for (int j = 0; j < n; j++) pay[j] = first + 8'(j);
    endtask

    // Three zero words of leader, sync starting at serial bit 24+s, payload,
    // then one trailing word that carries the spill-over bits.
    task automatic build(input logic [7:0] sync, input int s);
        logic [319:0] bits;
        bits = '0;
        bits[24+s +: 8] = sync;
        for (int j = 0; j < npay; j++) bits[32+s+8*j +: 8] = pay[j];
        wlen = 4 + npay + 1;
        for (int i = 0; i < wlen; i++) w[i] = bits[8*i +: 8];
    endtask

    task automatic drive(input int stop_at, input bit expect_lock);
        for (int i = 0; i < wlen && i < stop_at; i++) begin
            @(negedge clk);
            bus.data_in   = w[i];
            bus.align_rst = 1'b0;
            if (expect_lock && i >= 4 && (i - 4) < npay)
                q.push_back('{data: pay[i-4], cyc: cyc + 3});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.data_in   = 8'd0;
            bus.align_rst = 1'b0;
        end
    endtask

    // One-cycle re-hunt pulse; expectations due on or after that edge are
    // dropped because the pulse suppresses them.
    task automatic do_align();
        @(negedge clk);
        bus.data_in   = 8'd0;
        bus.align_rst = 1'b1;
        while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
        @(negedge clk);
        bus.align_rst = 1'b0;
        check("valid_after_align", 32'(bus.data_out_valid), 32'd0);
        check("locked_after_align", 32'(bus.locked), 32'd0);
        check("offset_after_align", 32'(bus.sync_offset), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in   = 8'd0;
        bus.align_rst = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_valid", 32'(bus.data_out_valid), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_offset", 32'(bus.sync_offset), 32'd0);
        rst = 1'b0;
        idle(2);

        // Sync shifted by 2 bits
        set_payload(8'h14, 4);
        build(8'hB8, 2);
        drive(99, 1'b1);
        idle(1);
        check("shift2_locked", 32'(bus.locked), 32'd1);
        check("shift2_offset", 32'(bus.sync_offset), 32'd2);
        do_align();
        check("data_out_hold", 32'(bus.data_out), 32'h17);

        // Byte-aligned burst; 0xB8 must never reach data_out
        pay[0] = 8'hA5; pay[1] = 8'h3C; npay = 2;
        build(8'hB8, 0);
        drive(99, 1'b1);
        idle(1);
        check("aligned_offset", 32'(bus.sync_offset), 32'd0);
        do_align();

        // Sweep of every bit offset, same payload each time
        for (int s = 0; s < 8; s++) begin
            set_payload(8'h14, 12);
            build(8'hB8, s);
            drive(99, 1'b1);
            idle(1);
            check("sweep_locked", 32'(bus.locked), 32'd1);
            check("sweep_offset", 32'(bus.sync_offset), 32'(s));
            do_align();
        end

        // Payload carrying the sync pattern at another offset and as a byte
        pay[0] = 8'hC0; pay[1] = 8'h05; pay[2] = 8'hB8; pay[3] = 8'h33; npay = 4;
        build(8'hB8, 6);
        drive(99, 1'b1);
        idle(1);
        check("payload_sync_offset", 32'(bus.sync_offset), 32'd6);
        do_align();

        // Re-hunt mid-payload, then relock on a burst at shift 5
        set_payload(8'h14, 12);
        build(8'hB8, 2);
        drive(8, 1'b1);
        do_align();
        check("mid_align_hold", 32'(bus.data_out), 32'h15);
        idle(2);
        set_payload(8'h20, 4);
        build(8'hB8, 5);
        drive(99, 1'b1);
        idle(1);
        check("relock_offset", 32'(bus.sync_offset), 32'd5);
        do_align();

        // Match coinciding with align_rst is discarded; held align_rst hunts nothing
        npay = 0;
        build(8'hB8, 0);
        drive(99, 1'b0);
        repeat (3) begin
            @(negedge clk);
            bus.data_in   = 8'hB8;
            bus.align_rst = 1'b1;
        end
        idle(3);
        check("align_wins_locked", 32'(bus.locked), 32'd0);

        // One-bit-corrupted sync: locks only with the soft option
        set_payload(8'h14, 4);
        build(8'hB9, 3);
        drive(99, SOFT);
        idle(1);
        check("soft_locked", 32'(bus.locked), SOFT ? 32'd1 : 32'd0);
        check("soft_offset", 32'(bus.sync_offset), SOFT ? 32'd3 : 32'd0);
        do_align();

        // Asynchronous reset mid-stream
        set_payload(8'h14, 12);
        build(8'hB8, 4);
        drive(8, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.data_in = 8'd0;
        #1;
        check("arst_data_out", 32'(bus.data_out), 32'd0);
        check("arst_valid", 32'(bus.data_out_valid), 32'd0);
        check("arst_locked", 32'(bus.locked), 32'd0);
        check("arst_offset", 32'(bus.sync_offset), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check("post_rst_locked", 32'(bus.locked), 32'd0);

        // Hunt works again after reset, highest offset
        set_payload(8'h14, 4);
        build(8'hB8, 7);
        drive(99, 1'b1);
        idle(1);
        check("shift7_offset", 32'(bus.sync_offset), 32'd7);
        do_align();

        idle(3);
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
